// File: rtl/mux_n_stream.sv
// Registered NUM_CH-way valid/ready stream multiplexer with an external channel select.
// Define MUX_N_RR_EN to add the round-robin arbiter (mode=1); without it mode is ignored.
module mux_n_stream #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
);

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic [SEL_W-1:0] ch_p1;

  logic             load_ok;
  logic             xfer;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic             gnt_sel_vld;
  logic [SEL_W-1:0] gnt_sel;
  logic [WIDTH-1:0] data_g;

  assign load_ok = !vld_p1 || out_ready;

  // Out-of-range select values match no channel, so they simply never grant.
  always_comb begin
    gnt_sel_vld = 1'b0;
    gnt_sel     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k) && in_valid[k]) begin
        gnt_sel_vld = 1'b1;
        gnt_sel     = SEL_W'(k);
      end
    end
  end

`ifdef MUX_N_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  logic             gnt_rr_vld;
  logic [SEL_W-1:0] gnt_rr;

  // Scan from the farthest offset down so the channel nearest rr_ptr wins.
  always_comb begin
    int idx;
    idx        = 0;
    gnt_rr_vld = 1'b0;
    gnt_rr     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (in_valid[idx]) begin
        gnt_rr_vld = 1'b1;
        gnt_rr     = SEL_W'(idx);
      end
    end
  end

  assign gnt_vld = mode ? gnt_rr_vld : gnt_sel_vld;
  assign gnt     = mode ? gnt_rr     : gnt_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer && mode) begin
      rr_ptr <= (gnt == SEL_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign gnt_vld     = gnt_sel_vld;
  assign gnt         = gnt_sel;
`endif

  // Ready is masked while reset is asserted so nothing is accepted into a clearing stage.
  assign xfer = gnt_vld && load_ok && rst_n;

  always_comb begin
    in_ready = '0;
    data_g   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_ready[k] = xfer && (gnt == SEL_W'(k));
      if (gnt == SEL_W'(k)) data_g = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Stage p1: output register; data and channel hold when no new beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (load_ok) begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= data_g;
        ch_p1   <= gnt;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_mux_n_stream.sv
// Directed bench for mux_n_stream: a 4x8 instance and a 5x16 instance on a shared clock/reset.
module tb_mux_n_stream;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        mode_a;
  logic [1:0]  sel_a;
  logic [31:0] in_data_a;
  logic [3:0]  in_valid_a;
  logic [3:0]  in_ready_a;
  logic [7:0]  out_data_a;
  logic        out_valid_a;
  logic        out_ready_a;
  logic [1:0]  out_ch_a;

  logic        mode_b;
  logic [2:0]  sel_b;
  logic [79:0] in_data_b;
  logic [4:0]  in_valid_b;
  logic [4:0]  in_ready_b;
  logic [15:0] out_data_b;
  logic        out_valid_b;
  logic        out_ready_b;
  logic [2:0]  out_ch_b;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_n_stream #(.WIDTH(8), .NUM_CH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode_a), .sel(sel_a),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_ch(out_ch_a)
  );

  mux_n_stream #(.WIDTH(16), .NUM_CH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode_b), .sel(sel_b),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_ch(out_ch_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    mode_a      = 1'b0;
    sel_a       = 2'd0;
    in_data_a   = '0;
    in_valid_a  = '0;
    out_ready_a = 1'b0;
    mode_b      = 1'b0;
    sel_b       = 3'd0;
    in_data_b   = '0;
    in_valid_b  = '0;
    out_ready_b = 1'b0;
    step();
    step();
    chk("rst_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst_data", {24'd0, out_data_a}, 32'd0);
    chk("rst_ch", {30'd0, out_ch_a}, 32'd0);
    rst_n = 1'b1;
    step();

    // select mode
    sel_a       = 2'd2;
    in_valid_a  = 4'b0100;
    in_data_a   = 32'h00A5_0000;
    out_ready_a = 1'b1;
    #1;
    chk("sel_ready", {28'd0, in_ready_a}, 32'h4);
    step();
    chk("sel_data", {24'd0, out_data_a}, 32'hA5);
    chk("sel_ch", {30'd0, out_ch_a}, 32'd2);
    chk("sel_valid", {31'd0, out_valid_a}, 32'd1);
    sel_a = 2'd3;
    #1;
    chk("sel_nogrant_ready", {28'd0, in_ready_a}, 32'h0);
    step();
    chk("sel_drain_valid", {31'd0, out_valid_a}, 32'd0);
    chk("sel_drain_hold", {24'd0, out_data_a}, 32'hA5);

    // backpressure: park 3C in the stage, then offer 11 on ch1
    sel_a       = 2'd0;
    in_valid_a  = 4'b0001;
    in_data_a   = 32'h0000_003C;
    out_ready_a = 1'b0;
    step();
    chk("bp_load", {24'd0, out_data_a}, 32'h3C);
    sel_a      = 2'd1;
    in_valid_a = 4'b0010;
    in_data_a  = 32'h0000_1100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", {28'd0, in_ready_a}, 32'h0);
      step();
      chk("bp_hold_data", {24'd0, out_data_a}, 32'h3C);
      chk("bp_hold_valid", {31'd0, out_valid_a}, 32'd1);
    end
    out_ready_a = 1'b1;
    #1;
    chk("bp_release_ready", {28'd0, in_ready_a}, 32'h2);
    step();
    chk("bp_new_data", {24'd0, out_data_a}, 32'h11);
    chk("bp_new_ch", {30'd0, out_ch_a}, 32'd1);
    chk("bp_new_valid", {31'd0, out_valid_a}, 32'd1);
    in_valid_a = 4'b0000;
    step();
    chk("bp_no_dup", {31'd0, out_valid_a}, 32'd0);

    in_data_a  = 32'h1312_1110;
    in_valid_a = 4'b1111;
    mode_a     = 1'b1;
`ifdef MUX_N_RR_EN
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_all_ch", {30'd0, out_ch_a}, i % 4);
      chk("rr_all_data", {24'd0, out_data_a}, 32'h10 + (i % 4));
      chk("rr_all_valid", {31'd0, out_valid_a}, 32'd1);
    end
    in_valid_a = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_sparse_ch", {30'd0, out_ch_a}, (i % 2 == 0) ? 32'd1 : 32'd3);
    end
`else
    sel_a = 2'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("nomacro_ch", {30'd0, out_ch_a}, 32'd1);
      chk("nomacro_data", {24'd0, out_data_a}, 32'h11);
    end
`endif
    mode_a     = 1'b0;
    in_valid_a = 4'b0000;
    step();

    // 5-channel, 16-bit instance: out-of-range select, then top channel
    sel_b       = 3'd7;
    in_valid_b  = 5'b11111;
    out_ready_b = 1'b1;
    in_data_b   = '0;
    in_data_b[64 +: 16] = 16'hBEEF;
    #1;
    chk("b_sel7_ready", {27'd0, in_ready_b}, 32'h0);
    step();
    chk("b_sel7_valid", {31'd0, out_valid_b}, 32'd0);
    sel_b = 3'd4;
    #1;
    chk("b_sel4_ready", {27'd0, in_ready_b}, 32'h10);
    step();
    chk("b_sel4_data", {16'd0, out_data_b}, 32'hBEEF);
    chk("b_sel4_ch", {29'd0, out_ch_b}, 32'd4);
    chk("b_sel4_valid", {31'd0, out_valid_b}, 32'd1);

    // asynchronous reset while a beat is held
    sel_a       = 2'd3;
    in_valid_a  = 4'b1000;
    in_data_a   = 32'h7700_0000;
    out_ready_a = 1'b0;
    step();
    chk("arst_pre_valid", {31'd0, out_valid_a}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid_a}, 32'd0);
    chk("arst_data", {24'd0, out_data_a}, 32'd0);
    chk("arst_ch", {30'd0, out_ch_a}, 32'd0);
    chk("arst_ready", {28'd0, in_ready_a}, 32'h0);
    chk("arst_b_valid", {31'd0, out_valid_b}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
